// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: drives the program ROM, buffers {pc, word} pairs in a
// small prefetch FIFO and hands them to decode. Optional feature: IFQ_MISALIGN_CHECK_EN.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFQ_MISALIGN_CHECK_EN
    output logic        fetch_misaligned,
`endif
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   word_q [DEPTH];
    logic          deq_s, enq_s, misal_s;

`ifdef IFQ_MISALIGN_CHECK_EN
    logic misal_q, misal_d;

    // Misalignment flag is only changed by a redirect; it blocks fetch until cleared.
    always_comb begin
        misal_d = misal_q;
        if (redirect_valid) begin
            misal_d = (redirect_pc[1:0] != 2'b00);
        end else begin
            misal_d = misal_q;
        end
    end

    // Misalignment flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= misal_d;
        end
    end

    assign misal_s          = misal_q;
    assign fetch_misaligned = misal_q;
`else
    assign misal_s = 1'b0;
`endif

    // Handshake decode and pointer/count/PC next-state; redirect overrides everything.
    always_comb begin
        deq_s   = (count_q != {CW{1'b0}}) && instr_ready && !redirect_valid;
        enq_s   = !redirect_valid && !misal_s && ((count_q != FULL) || deq_s);
        fpc_d   = fpc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (redirect_valid) begin
            fpc_d   = redirect_pc & ~32'h0000_0003;
            rptr_d  = {PW{1'b0}};
            wptr_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            fpc_d   = enq_s ? (fpc_q + 32'd4) : fpc_q;
            rptr_d  = deq_s ? (rptr_q + PW'(1)) : rptr_q;
            wptr_d  = enq_s ? (wptr_q + PW'(1)) : wptr_q;
            count_d = count_q + CW'(enq_s) - CW'(deq_s);
        end
    end

    // Fetch PC, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q   <= RESET_PC;
            rptr_q  <= {PW{1'b0}};
            wptr_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            fpc_q   <= fpc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; entries are only cleared by reset, a flush just rewinds pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'h0000_0000;
                word_q[i] <= 32'h0000_0000;
            end
        end else if (enq_s) begin
            pc_q[wptr_q]   <= fpc_q;
            word_q[wptr_q] <= rom_data;
        end
    end

    assign rom_addr    = fpc_q;
    assign instr_valid = (count_q != {CW{1'b0}});
    assign instr       = word_q[rptr_q];
    assign instr_pc    = pc_q[rptr_q];

endmodule
